// File: rtl/section_rx_arb_if.sv
// Channel-side and consumer-side handshake bundle for section_rx_arb.
// master = the arbiter, slave = producers/consumer around it.
interface section_rx_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] ch_in;
  logic [NUM_CH-1:0]        ch_in_sync;
  logic [NUM_CH-1:0]        ch_in_notify;
  logic [DATA_W-1:0]        out_data;
  logic                     out_sync;
  logic                     out_notify;
  logic [GW-1:0]            grant_ch;
  logic [15:0]              xfer_cnt;

  modport master (
    input  ch_in, ch_in_sync, out_sync,
    output ch_in_notify, out_data, out_notify, grant_ch, xfer_cnt
  );

  modport slave (
    output ch_in, ch_in_sync, out_sync,
    input  ch_in_notify, out_data, out_notify, grant_ch, xfer_cnt
  );
endinterface

// File: rtl/section_rx_arb.sv
// Round-robin read of NUM_CH blocking channels, one item at a time forwarded to a
// single consumer; read section and write section alternate, MODE=1 accumulates.
module section_rx_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  section_rx_arb_if.master  bus
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] SECTION_A = 1'b0;
  localparam logic [0:0] SECTION_B = 1'b1;

  logic [0:0]        section;
  logic [DATA_W-1:0] x_signal;
  logic [DATA_W-1:0] sel_dat;
  logic [DATA_W-1:0] cap_dat;
  logic              sel_sync;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     rr_nxt;

  function automatic logic [NUM_CH-1:0] onehot(input logic [GW-1:0] p);
    return {{(NUM_CH-1){1'b0}}, 1'b1} << p;
  endfunction

  // Only the channel under the pointer is ever looked at; other syncs are ignored.
  always_comb begin
    sel_dat  = '0;
    sel_sync = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rr_ptr == GW'(k)) begin
        sel_dat  = bus.ch_in[k*DATA_W +: DATA_W];
        sel_sync = bus.ch_in_sync[k];
      end
    end
  end

  assign rr_nxt  = (rr_ptr == GW'(NUM_CH-1)) ? '0 : rr_ptr + GW'(1);
  assign cap_dat = (MODE == 1) ? x_signal + sel_dat : sel_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section          <= SECTION_A;
      x_signal         <= '0;
      rr_ptr           <= '0;
      bus.ch_in_notify <= onehot('0);
      bus.out_notify   <= 1'b0;
      bus.out_data     <= '0;
      bus.grant_ch     <= '0;
      bus.xfer_cnt     <= '0;
    end else begin
      case (section)
        SECTION_A: begin
          rr_ptr <= rr_nxt;
          if (sel_sync) begin
            x_signal         <= cap_dat;
            bus.out_data     <= cap_dat;
            bus.grant_ch     <= rr_ptr;
            bus.ch_in_notify <= '0;
            bus.out_notify   <= 1'b1;
            section          <= SECTION_B;
          end else begin
            bus.ch_in_notify <= onehot(rr_nxt);
          end
        end
        default: begin
          // Wait indefinitely for the consumer; pointer already sits on the next channel.
          if (bus.out_sync) begin
            bus.out_notify   <= 1'b0;
            bus.xfer_cnt     <= bus.xfer_cnt + 16'd1;
            bus.ch_in_notify <= onehot(rr_ptr);
            section          <= SECTION_A;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_section_rx_arb.sv
// Bench for section_rx_arb: instance 0 is MODE=0/32-bit, instance 1 is MODE=1/8-bit.
// Both run against a transaction-level reference model every cycle.
module tb_section_rx_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  section_rx_arb_if #(.NUM_CH(4), .DATA_W(32)) if0 ();
  section_rx_arb_if #(.NUM_CH(4), .DATA_W(8))  if1 ();

  section_rx_arb #(.NUM_CH(4), .DATA_W(32), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  section_rx_arb #(.NUM_CH(4), .DATA_W(8),  .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int unsigned din [2][4];
  logic [3:0]  sync_v [2];
  logic        osync_v [2];

  assign if0.ch_in      = {din[0][3], din[0][2], din[0][1], din[0][0]};
  assign if1.ch_in      = {din[1][3][7:0], din[1][2][7:0], din[1][1][7:0], din[1][0][7:0]};
  assign if0.ch_in_sync = sync_v[0];
  assign if1.ch_in_sync = sync_v[1];
  assign if0.out_sync   = osync_v[0];
  assign if1.out_sync   = osync_v[1];

  logic [3:0]  act_notify [2];
  logic        act_onot   [2];
  logic [31:0] act_data   [2];
  logic [1:0]  act_grant  [2];
  logic [15:0] act_cnt    [2];
  assign act_notify[0] = if0.ch_in_notify;
  assign act_notify[1] = if1.ch_in_notify;
  assign act_onot[0]   = if0.out_notify;
  assign act_onot[1]   = if1.out_notify;
  assign act_data[0]   = if0.out_data;
  assign act_data[1]   = {24'd0, if1.out_data};
  assign act_grant[0]  = if0.grant_ch;
  assign act_grant[1]  = if1.grant_ch;
  assign act_cnt[0]    = if0.xfer_cnt;
  assign act_cnt[1]    = if1.xfer_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: "waiting for consumer" flag, integer pointer, running sum, counters.
  bit          m_wait  [2];
  int          m_ptr   [2];
  int unsigned m_acc   [2];
  int unsigned m_out   [2];
  int          m_grant [2];
  int          m_cnt   [2];

  function automatic int unsigned wmask(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 1'b0; m_ptr[i] = 0; m_acc[i] = 0;
      m_out[i] = 0; m_grant[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    int unsigned d;
    int unsigned v;
    for (int i = 0; i < 2; i++) begin
      if (!m_wait[i]) begin
        if (sync_v[i][m_ptr[i]]) begin
          d = din[i][m_ptr[i]] & wmask(i);
          v = (i == 1) ? ((m_acc[i] + d) & wmask(i)) : d;
          m_acc[i]   = v;
          m_out[i]   = v;
          m_grant[i] = m_ptr[i];
          m_wait[i]  = 1'b1;
        end
        m_ptr[i] = (m_ptr[i] + 1) % 4;
      end else if (osync_v[i]) begin
        m_wait[i] = 1'b0;
        m_cnt[i]  = (m_cnt[i] + 1) % 65536;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] en;
    for (int i = 0; i < 2; i++) begin
      en = m_wait[i] ? 4'b0000 : (4'b0001 << m_ptr[i]);
      n_vec++;
      if (act_notify[i] !== en || act_onot[i] !== m_wait[i] || act_data[i] !== m_out[i] ||
          act_grant[i] !== 2'(m_grant[i]) || act_cnt[i] !== 16'(m_cnt[i])) begin
        n_bad++;
        $display("FAIL %s inst%0d: got notify=%b onot=%b data=%h grant=%0d cnt=%0d, want notify=%b onot=%b data=%h grant=%0d cnt=%0d",
                 tag, i, act_notify[i], act_onot[i], act_data[i], act_grant[i], act_cnt[i],
                 en, m_wait[i], m_out[i], m_grant[i], m_cnt[i]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  // Called at a negedge; reset is raised mid-cycle and checked before any clock edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_model("rst_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  sync;
    logic        osync;
    logic [3:0]  notify;
    logic        onot;
    logic [31:0] data;
    int          grant;
    int          cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 32'h0,  0, 0};
    tbl[1] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 32'h0,  0, 0};
    tbl[2] = '{4'b0000, 1'b0, 4'b1000, 1'b0, 32'h0,  0, 0};
    tbl[3] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 32'h0,  0, 0};
    tbl[4] = '{4'b0100, 1'b1, 4'b0010, 1'b0, 32'h0,  0, 0};
    tbl[5] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 32'h0,  0, 0};
    tbl[6] = '{4'b0100, 1'b1, 4'b0000, 1'b1, 32'hA5, 2, 0};
    tbl[7] = '{4'b0000, 1'b1, 4'b1000, 1'b0, 32'hA5, 2, 1};

    for (int i = 0; i < 2; i++) begin
      sync_v[i] = '0; osync_v[i] = 1'b0;
      for (int k = 0; k < 4; k++) din[i][k] = 0;
    end
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset_state");
    chk("reset_notify", {28'd0, act_notify[0]}, 32'h1);
    rst = 1'b0;

    // Idle rotation, then a capture on channel 2 with other syncs ignored.
    din[0][2] = 32'h0000_00A5;
    for (int j = 0; j < 8; j++) begin
      sync_v[0]  = tbl[j].sync;
      osync_v[0] = tbl[j].osync;
      step("table_model");
      n_vec++;
      if (act_notify[0] !== tbl[j].notify || act_onot[0] !== tbl[j].onot ||
          act_data[0] !== tbl[j].data || act_grant[0] !== 2'(tbl[j].grant) ||
          act_cnt[0] !== 16'(tbl[j].cnt)) begin
        n_bad++;
        $display("FAIL table[%0d]: got notify=%b onot=%b data=%h grant=%0d cnt=%0d, want notify=%b onot=%b data=%h grant=%0d cnt=%0d",
                 j, act_notify[0], act_onot[0], act_data[0], act_grant[0], act_cnt[0],
                 tbl[j].notify, tbl[j].onot, tbl[j].data, tbl[j].grant, tbl[j].cnt);
      end
    end

    // Saturated producers and consumer: one output every 2 cycles, grants 0,1,2,3,0.
    pulse_reset();
    for (int k = 0; k < 4; k++) din[0][k] = 32'h100 + k;
    sync_v[0] = 4'b1111; osync_v[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step("rr_full");
      chk("rr_grant", {30'd0, act_grant[0]}, n % 4);
      chk("rr_onot_hi", {31'd0, act_onot[0]}, 32'h1);
      step("rr_full");
      chk("rr_cnt", {16'd0, act_cnt[0]}, n + 1);
    end

    // Consumer stall for 10 cycles with every producer ready.
    pulse_reset();
    sync_v[0] = 4'b1111; osync_v[0] = 1'b0;
    step("stall");
    for (int n = 0; n < 10; n++) begin
      step("stall");
      chk("stall_data", act_data[0], 32'h100);
      chk("stall_notify", {28'd0, act_notify[0], act_onot[0]} , 32'h1);
    end
    osync_v[0] = 1'b1; sync_v[0] = 4'b0000;
    step("stall_release");
    chk("stall_cnt", {16'd0, act_cnt[0]}, 32'h1);
    osync_v[0] = 1'b0;

    // Accumulator wraps modulo 2^8.
    pulse_reset();
    din[1][0] = 32'hF0; sync_v[1] = 4'b0001; osync_v[1] = 1'b1;
    step("acc");
    chk("acc_first", act_data[1], 32'hF0);
    step("acc");
    din[1][0] = 32'h20;
    repeat (4) step("acc");
    chk("acc_wrap", act_data[1], 32'h10);
    step("acc");
    chk("acc_cnt", {16'd0, act_cnt[1]}, 32'h2);
    sync_v[1] = 4'b0000; osync_v[1] = 1'b0;

    // Reset while an item is pending at the consumer.
    pulse_reset();
    din[0][0] = 32'h55; sync_v[0] = 4'b0001;
    step("pend");
    chk("pend_data", act_data[0], 32'h55);
    sync_v[0] = 4'b0000;
    pulse_reset();
    chk("pend_rst", {act_data[0][15:0], act_cnt[0][11:0], act_notify[0]}, 32'h0000_0001);
    chk("pend_rst_onot", {31'd0, act_onot[0]}, 32'h0);

    // Random traffic on both instances with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        sync_v[i]  = 4'($urandom_range(0, 15));
        osync_v[i] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) din[i][k] = $urandom;
      end
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
